// File: rtl/pll_ce_rst_gen_pkg.sv
// Shared types and default rates for the PLL-side CE / reset sequencer.
package pll_ce_rst_gen_pkg;

  typedef enum logic [1:0] {S_WAIT, S_STABLE, S_HOLD, S_RUN} state_e;

  // Defaults give 53.69 MHz CEs from the 107.386350 MHz PLL clock.
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_DIV           = 2;
  localparam int DEF_RST_HOLD_CES  = 8;

endpackage

// File: rtl/pll_ce_rst_gen_sync_bit.sv
// Single-bit multi-flop synchroniser with synchronous active-low reset.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clk) begin
    if (!rst_n) stg <= '0;
    else        stg <= {stg[SYNC_STAGES-2:0], d};
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/pll_ce_rst_gen.sv
// Lock-qualified CE_R/CE_F generator and core reset sequencer behind the system PLL.
module pll_ce_rst_gen
  import pll_ce_rst_gen_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int DIV           = DEF_DIV,
  parameter int RST_HOLD_CES  = DEF_RST_HOLD_CES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic PLL_LOCKED,
  input  logic PAUSE,
  input  logic LOCK_LOST_CLR,
  output logic CE_R,
  output logic CE_F,
  output logic SYS_RST_N,
  output logic LOCK_LOST
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = $clog2(DIV);
  localparam int HW = $clog2(RST_HOLD_CES + 1);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
  localparam logic [DW-1:0] FALL_AT     = DW'(DIV / 2 - 1);
  localparam logic [HW-1:0] HOLD_N      = HW'(RST_HOLD_CES);

  logic lock_s;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (PLL_LOCKED),
    .q     (lock_s)
  );

  state_e        state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ce_r_q, ce_r_d, ce_f_q, ce_f_d;
  logic          srst_q, srst_d, ll_q, ll_d, ll_set;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_WAIT;
      stab_q  <= '0;
      div_q   <= '0;
      hold_q  <= '0;
      ce_r_q  <= 1'b0;
      ce_f_q  <= 1'b0;
      srst_q  <= 1'b0;
      ll_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      div_q   <= div_d;
      hold_q  <= hold_d;
      ce_r_q  <= ce_r_d;
      ce_f_q  <= ce_f_d;
      srst_q  <= srst_d;
      ll_q    <= ll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    div_d   = div_q;
    hold_d  = hold_q;
    ce_r_d  = 1'b0;
    ce_f_d  = 1'b0;
    srst_d  = srst_q;
    ll_set  = 1'b0;
    case (state_q)
      S_WAIT: begin
        stab_d = '0;
        div_d  = '0;
        hold_d = '0;
        srst_d = 1'b0;
        if (lock_s) state_d = S_STABLE;
      end
      S_STABLE: begin
        srst_d = 1'b0;
        if (!lock_s) begin
          state_d = S_WAIT;
        end else if (stab_q == STABLE_LAST) begin
          // First CE_R goes out on the same edge that enters S_HOLD.
          state_d = S_HOLD;
          ce_r_d  = 1'b1;
          div_d   = '0;
          hold_d  = HW'(1);
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      default: begin // S_HOLD, S_RUN
        if (!lock_s) begin
          state_d = S_WAIT;
          srst_d  = 1'b0;
          div_d   = '0;
          hold_d  = '0;
          ll_set  = 1'b1;
        end else begin
          // A CE_F due this period fires even while a pause is holding the wrap.
          ce_f_d = (div_q == FALL_AT);
          if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
          end else if (state_q == S_HOLD) begin
            ce_r_d = 1'b1;
            div_d  = '0;
            if (hold_q == HOLD_N) begin
              state_d = S_RUN;
              srst_d  = 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end else if (!PAUSE) begin
            ce_r_d = 1'b1;
            div_d  = '0;
          end
        end
      end
    endcase
    ll_d = ll_set | (ll_q & ~LOCK_LOST_CLR);
  end

  assign CE_R      = ce_r_q;
  assign CE_F      = ce_f_q;
  assign SYS_RST_N = srst_q;
  assign LOCK_LOST = ll_q;

endmodule

// File: tb/tb_pll_ce_rst_gen.sv
// Directed bench: DUT A (DIV=4) drives the vector table, DUT B (DIV=2) checks cadence and mid-hold reset.
module tb_pll_ce_rst_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n = 1'b0, a_locked = 1'b0, a_pause = 1'b0, a_clr = 1'b0;
  logic a_ce_r, a_ce_f, a_srst, a_ll;
  logic b_rst_n = 1'b0, b_locked = 1'b1;
  logic b_ce_r, b_ce_f, b_srst, b_ll;

  pll_ce_rst_gen #(.SYNC_STAGES(2), .STABLE_CYCLES(16), .DIV(4), .RST_HOLD_CES(2)) dut_a (
    .CLK(clk), .RST_N(a_rst_n), .PLL_LOCKED(a_locked), .PAUSE(a_pause),
    .LOCK_LOST_CLR(a_clr), .CE_R(a_ce_r), .CE_F(a_ce_f), .SYS_RST_N(a_srst), .LOCK_LOST(a_ll));

  pll_ce_rst_gen #(.SYNC_STAGES(2), .STABLE_CYCLES(16), .DIV(2), .RST_HOLD_CES(2)) dut_b (
    .CLK(clk), .RST_N(b_rst_n), .PLL_LOCKED(b_locked), .PAUSE(1'b0),
    .LOCK_LOST_CLR(1'b0), .CE_R(b_ce_r), .CE_F(b_ce_f), .SYS_RST_N(b_srst), .LOCK_LOST(b_ll));

  typedef struct {
    logic       rst_n, locked, pause, clr;
    int         n;      // edges to run before comparing
    logic [3:0] exp;    // {CE_R, CE_F, SYS_RST_N, LOCK_LOST}
  } vec_t;

  vec_t v[32];
  int   nv = 0;
  int   n_vec = 0, n_miss = 0;
  int   cnt_r = 0, cnt_f = 0;

  always @(negedge clk) begin
    if (a_ce_r) cnt_r++;
    if (a_ce_f) cnt_f++;
  end

  task automatic add(input logic r, input logic l, input logic p, input logic c,
                     input int n, input logic [3:0] e);
    v[nv] = '{rst_n: r, locked: l, pause: p, clr: c, n: n, exp: e};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got {ce_r,ce_f,srst,ll}=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      a_rst_n  = v[i].rst_n;
      a_locked = v[i].locked;
      a_pause  = v[i].pause;
      a_clr    = v[i].clr;
      repeat (v[i].n) tick();
      chk($sformatf("vec[%0d]", i), {a_ce_r, a_ce_f, a_srst, a_ll}, v[i].exp);
    end
  endtask

  initial begin
    // Power-up: edge 0 is the first edge after RST_N release.
    add(0, 1, 0, 0, 5,  4'b0000);
    add(1, 1, 0, 0, 18, 4'b0000);  // edge 17
    add(1, 1, 0, 0, 1,  4'b1000);  // edge 18 first CE_R
    add(1, 1, 0, 0, 1,  4'b0000);
    add(1, 1, 0, 0, 1,  4'b0100);  // edge 20 CE_F
    add(1, 1, 0, 0, 1,  4'b0000);
    add(1, 1, 0, 0, 1,  4'b1000);  // edge 22
    add(1, 1, 0, 0, 2,  4'b0100);  // edge 24
    add(1, 1, 0, 0, 2,  4'b1010);  // edge 26 third CE_R with SYS_RST_N rise
    add(1, 1, 0, 0, 1,  4'b0010);
    add(1, 1, 0, 0, 1,  4'b0110);  // edge 28
    add(1, 1, 0, 0, 2,  4'b1010);  // edge 30
    // Lock loss in S_RUN.
    add(1, 0, 0, 0, 1,  4'b0010);  // low sampled
    add(1, 0, 0, 0, 1,  4'b0110);  // pending CE_F still in flight
    add(1, 0, 0, 0, 1,  4'b0001);  // 2 edges after sample: reset + sticky
    add(1, 0, 0, 1, 1,  4'b0000);  // clear
    add(1, 1, 0, 0, 27, 4'b1010);  // full resequence to edge 26
    add(1, 0, 0, 0, 2,  4'b0110);
    add(1, 0, 0, 1, 1,  4'b0001);  // set beats clear
    add(1, 0, 0, 1, 1,  4'b0000);
    add(1, 0, 0, 0, 1,  4'b0000);  // idx 20
    // Restart after an early drop.
    add(1, 1, 0, 0, 26, 4'b0000);  // edge 25: still in reset
    add(1, 1, 0, 0, 1,  4'b1010);  // edge 26

    run_vecs(0, 20);

    // Early lock drop: nothing may come out and LOCK_LOST must stay clear.
    a_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("early_hi[%0d]", i), {a_ce_r, a_ce_f, a_srst, a_ll}, 4'b0000);
    end
    a_locked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("early_lo[%0d]", i), {a_ce_r, a_ce_f, a_srst, a_ll}, 4'b0000);
    end

    run_vecs(21, 22);

    // Pause asserted the cycle after a CE_R and held 10 cycles.
    a_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("pause[%0d]", i), {a_ce_r, a_ce_f, a_srst, a_ll},
          {1'b0, (i == 1), 1'b1, 1'b0});
    end
    a_pause = 1'b0;
    tick();
    chk("pause_release", {a_ce_r, a_ce_f, a_srst, a_ll}, 4'b1010);
    tick();
    tick();
    chk("pause_post_f", {a_ce_r, a_ce_f, a_srst, a_ll}, 4'b0110);
    tick();
    chk_int("ce_r_total", cnt_r, 11);
    chk_int("ce_f_total", cnt_f, 11);

    // Sticky flag set, then cleared by RST_N.
    a_locked = 1'b0;
    repeat (3) tick();
    chk("loss_before_rst", {a_ce_r, a_ce_f, a_srst, a_ll}, 4'b0001);
    a_rst_n = 1'b0;
    tick();
    chk("rst_clears_ll", {a_ce_r, a_ce_f, a_srst, a_ll}, 4'b0000);

    // DIV=2: SYS_RST_N at edge 2+16+2*2=22, then CE_R/CE_F alternate.
    b_rst_n = 1'b1;
    repeat (22) tick();
    chk("b_edge21", {b_ce_r, b_ce_f, b_srst, b_ll}, 4'b0100);
    tick();
    chk("b_run_start", {b_ce_r, b_ce_f, b_srst, b_ll}, 4'b1010);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("b_alt[%0d]", i), {b_ce_r, b_ce_f, b_srst, b_ll},
          {i[0], ~i[0], 1'b1, 1'b0});
    end
    b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    repeat (20) tick();
    chk("b_hold_f", {b_ce_r, b_ce_f, b_srst, b_ll}, 4'b0100);
    b_rst_n = 1'b0;
    tick();
    chk("b_rst_mid_hold", {b_ce_r, b_ce_f, b_srst, b_ll}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pll_ce_rst_gen.md
Name: pll_ce_rst_gen

Overview:
- Sits directly downstream of the system PLL and runs on the 107.386350 MHz PLL output.
- Synchronises the asynchronous PLL lock flag and waits for lock to remain stable.
- Generates paired rise/fall clock enables (CE_R/CE_F) for the CE-driven core logic.
- Sequences the core's synchronous reset so the core sees CE pulses while still held in reset.
- On lock loss it returns the core to reset immediately and records a sticky fault flag.

Parameters:
- SYNC_STAGES, 2: flops in the PLL_LOCKED synchroniser; must be ≥2.
- STABLE_CYCLES, 1024: CLK cycles lock must stay high before CEs start; must be ≥1.
- DIV, 2: CLK cycles per CE period; must be even and ≥2. DIV=2 gives 53.69 MHz CEs.
- RST_HOLD_CES, 8: number of CE_R pulses issued while SYS_RST_N is still low; must be ≥1.

Ports:
- CLK  in  1  107.386350 MHz PLL output clock.
- RST_N  in  1  synchronous, active-low reset.
- PLL_LOCKED  in  1  PLL lock flag, asynchronous to CLK.
- PAUSE  in  1  freezes CE generation at a period boundary.
- LOCK_LOST_CLR  in  1  clears LOCK_LOST.
- CE_R  out  1  rise-phase clock enable, one CLK cycle wide.
- CE_F  out  1  fall-phase clock enable, one CLK cycle wide.
- SYS_RST_N  out  1  core reset, synchronous, active-low.
- LOCK_LOST  out  1  sticky flag: lock dropped after the CE sequence had started.

Behaviour:
- Interface: one clock, CLK. Reset RST_N is synchronous and active-low; every register is reset on a CLK edge while RST_N=0.
- Reset values: synchroniser stages 0, state S_WAIT, all counters 0, CE_R=0, CE_F=0, SYS_RST_N=0, LOCK_LOST=0.
- All outputs are registered; there is no combinational path from any input to any output.
- lock_s is the last synchroniser stage. It follows PLL_LOCKED SYNC_STAGES edges after PLL_LOCKED is sampled.
- State S_WAIT:
  - CEs 0, SYS_RST_N 0, divider held at 0.
  - lock_s=1 → S_STABLE with the stable counter cleared.
- State S_STABLE:
  - Stable counter increments every cycle; CEs 0, SYS_RST_N 0.
  - lock_s=0 → S_WAIT. LOCK_LOST is not set from this state.
  - After exactly STABLE_CYCLES cycles in this state → S_HOLD.
- State S_HOLD:
  - CE_R is asserted in the first cycle of S_HOLD, then every DIV cycles.
  - CE_F is asserted DIV/2 cycles after each CE_R.
  - PAUSE is ignored.
  - After RST_HOLD_CES CE_R pulses, the edge that would issue the next CE_R also moves to S_RUN and sets SYS_RST_N=1. That CE_R is still issued, coincident with the SYS_RST_N rise.
- State S_RUN:
  - SYS_RST_N=1; CE cadence continues unchanged from S_HOLD.
- Timing example: with PLL_LOCKED sampled high at edge 0, SYS_RST_N rises after edge SYNC_STAGES + STABLE_CYCLES + RST_HOLD_CES×DIV.
- PAUSE (S_RUN only):
  - Evaluated only at the divider wrap, i.e. when the next CE_R is due.
  - PAUSE=1 there: the divider holds at wrap and no CE_R is issued.
  - A CE_F already due in the current period always fires, so CE_R/CE_F stay paired.
  - PAUSE=0: the held CE_R fires on the next edge and the cadence resumes.
- Lock loss:
  - lock_s=0 while in S_HOLD or S_RUN causes, on the next edge: state S_WAIT, SYS_RST_N=0, CE_R=CE_F=0, LOCK_LOST=1.
  - Total latency is SYNC_STAGES cycles from PLL_LOCKED sampled low. Any pending CE_F is dropped.
- LOCK_LOST_CLR=1 clears LOCK_LOST. If a set and a clear occur in the same cycle, the set wins.
- A lock glitch shorter than one CLK period may be missed by the synchroniser; this is acceptable.
- RST_N low mid-sequence returns everything to reset values on the next edge, including clearing LOCK_LOST.
- Counter widths:
  - Stable counter: $clog2(STABLE_CYCLES+1).
  - Divider: $clog2(DIV).
  - Hold counter: $clog2(RST_HOLD_CES+1).
  - Counters never wrap past their terminal count.

Decomposition:
- Shared package holds:
  - the state enum (S_WAIT, S_STABLE, S_HOLD, S_RUN);
  - default DIV/STABLE_CYCLES constants for the 53.69 MHz CE rate.
- One sub-module: sync_bit, a SYNC_STAGES-deep single-bit synchroniser with synchronous active-low reset.

Test Plan:
- Test parameters: SYNC_STAGES=2, STABLE_CYCLES=16, DIV=4, RST_HOLD_CES=2.
- Power-up: RST_N=0 for 5 cycles with PLL_LOCKED=1 → all outputs 0. Release RST_N → CE_R first high 18 cycles after release; SYS_RST_N rises 26 cycles after release, coincident with the 3rd CE_R; CE_F is 2 cycles after each CE_R.
- Early lock drop: PLL_LOCKED high 10 cycles, then low → no CE pulse ever, LOCK_LOST stays 0. Re-raise PLL_LOCKED → the full sequence restarts from zero.
- Lock loss in run: drop PLL_LOCKED while SYS_RST_N=1 → 2 cycles later SYS_RST_N=0, CEs 0, LOCK_LOST=1. Assert LOCK_LOST_CLR together with a fresh loss event → LOCK_LOST stays 1.
- Pause: assert PAUSE 1 cycle after a CE_R, hold 10 cycles → the following CE_F still fires, then no CE_R until 1 cycle after PAUSE drops; CE_R:CE_F count ratio stays exactly 1:1.
- DIV=2 build: CE_R and CE_F alternate every cycle in S_RUN, never both high in the same cycle. RST_N mid-S_HOLD → all outputs 0 on the next edge.
